// File: rtl/pointer_pkg.sv
// Shared state/mode types, packet bit layout and the frame builder
// for the CD-i pointing-device generator.
package pointer_pkg;

  typedef enum logic [2:0] {
    DEVICE_ID,
    IDLE,
    BYTE0,
    BYTE1,
    BYTE2,
    BYTE3
  } e_state;

  typedef enum logic {
    MODE_REL = 1'b0,
    MODE_ABS = 1'b1
  } e_mode;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_B2    = 4;
  localparam int JOY_B1    = 5;

  localparam logic [1:0] HDR_FIRST = 2'b11;
  localparam logic [1:0] HDR_NEXT  = 2'b10;

  localparam int CAPTURE_CNT = 10;
  localparam int POS_W       = 10;

  typedef logic [3:0][7:0] frame_t;

  // Relative mode only looks at the low 8 bits of x/y (signed deltas).
  function automatic frame_t build_frame(input e_mode            mode,
                                         input logic             b1,
                                         input logic             b2,
                                         input logic [POS_W-1:0] x,
                                         input logic [POS_W-1:0] y);
    frame_t f;
    f[1] = {HDR_NEXT, x[5:0]};
    f[2] = {HDR_NEXT, y[5:0]};
    if (mode == MODE_REL) begin
      f[0] = {HDR_FIRST, b1, b2, y[7:6], x[7:6]};
      f[3] = 8'h00;
    end else begin
      f[0] = {HDR_FIRST, b1, b2, x[9:8], y[9:8]};
      f[3] = {HDR_NEXT, 2'b00, x[7:6], y[7:6]};
    end
    return f;
  endfunction

endpackage

// File: rtl/bytestream.sv
// Byte-wide stream with a single-cycle write strobe.
interface bytestream;
  logic [7:0] data;
  logic       write;

  modport source (output data, output write);
  modport sink   (input  data, input  write);
endinterface

// File: rtl/pointer_motion.sv
// Speed/acceleration, per-report delta and clamped absolute position.
// POINTER_ANALOG_EN adds an analog-stick delta used when no direction is held.
module pointer_motion
  import pointer_pkg::*;
#(
  parameter int SPEED_SLOW    = 2,
  parameter int SPEED_FAST    = 8,
  parameter int SPEED_FAST_OC = 7,
  parameter int ACCEL_THRESH  = 5,
  parameter int ACCEL_MAX     = 7,
  parameter int X_MAX         = 767,
  parameter int Y_MAX         = 559
`ifdef POINTER_ANALOG_EN
  ,
  parameter int DEADZONE      = 16
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          dir_i,
  input  logic                overclock_i,
  input  logic                update_i,
  input  logic                abs_en_i,
`ifdef POINTER_ANALOG_EN
  input  logic [15:0]         analog_i,
`endif
  output logic signed [7:0]   dx_o,
  output logic signed [7:0]   dy_o,
  output logic [POS_W-1:0]    pos_x_o,
  output logic [POS_W-1:0]    pos_y_o,
  output logic                pos_changed_o
);

  localparam int ACC_W = $clog2(ACCEL_MAX + 1);
  localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX);

  logic [ACC_W-1:0]  accel_q, accel_d;
  logic [POS_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [7:0] speed, dig_dx, dig_dy;

  function automatic logic [POS_W-1:0] clamp_add(input logic [POS_W-1:0] pos,
                                                 input logic signed [7:0] d,
                                                 input logic [POS_W-1:0]  lim);
    logic signed [POS_W:0] sum;
    sum = $signed({1'b0, pos}) + $signed({{(POS_W-7){d[7]}}, d});
    if (sum[POS_W])
      return '0;
    else if (sum > $signed({1'b0, lim}))
      return lim;
    else
      return sum[POS_W-1:0];
  endfunction

  always_comb begin
    speed = 8'(SPEED_SLOW);
    if (accel_q >= ACC_W'(ACCEL_THRESH))
      speed = overclock_i ? 8'(SPEED_FAST_OC) : 8'(SPEED_FAST);
  end

  // Left beats right and up beats down when both are held.
  always_comb begin
    dig_dx = '0;
    dig_dy = '0;
    if (dir_i[JOY_LEFT])
      dig_dx = -speed;
    else if (dir_i[JOY_RIGHT])
      dig_dx = speed;
    if (dir_i[JOY_UP])
      dig_dy = -speed;
    else if (dir_i[JOY_DOWN])
      dig_dy = speed;
  end

`ifdef POINTER_ANALOG_EN
  function automatic logic signed [7:0] analog_step(input logic signed [7:0] axis);
    logic [8:0] mag;
    logic [8:0] step;
    mag  = axis[7] ? 9'(-$signed({axis[7], axis})) : {1'b0, axis};
    step = '0;
    if (mag > 9'(DEADZONE)) begin
      step = mag >> 4;
      if (step > 9'(SPEED_FAST))
        step = 9'(SPEED_FAST);
    end
    return axis[7] ? -$signed(step[7:0]) : $signed(step[7:0]);
  endfunction

  always_comb begin
    dx_o = dig_dx;
    dy_o = dig_dy;
    if (dir_i == '0) begin
      dx_o = analog_step(analog_i[7:0]);
      dy_o = analog_step(analog_i[15:8]);
    end
  end
`else
  assign dx_o = dig_dx;
  assign dy_o = dig_dy;
`endif

  always_comb begin
    accel_d = accel_q;
    if (update_i) begin
      if (dir_i == '0)
        accel_d = '0;
      else if (accel_q != ACC_W'(ACCEL_MAX))
        accel_d = accel_q + 1'b1;
    end
  end

  assign pos_x_o       = clamp_add(pos_x_q, dx_o, X_LIM);
  assign pos_y_o       = clamp_add(pos_y_q, dy_o, Y_LIM);
  assign pos_changed_o = (pos_x_o != pos_x_q) || (pos_y_o != pos_y_q);

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (update_i && abs_en_i) begin
      pos_x_d = pos_x_o;
      pos_y_d = pos_y_o;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accel_q <= '0;
      pos_x_q <= POS_W'(X_MAX / 2);
      pos_y_q <= POS_W'(Y_MAX / 2);
    end else begin
      accel_q <= accel_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

endmodule

// File: rtl/cdi_pointer_gen.sv
// CD-i pointing-device emulator: joystick state to paced serial bytes (relative or absolute).
// Optional POINTER_ANALOG_EN adds joystick_analog and the DEADZONE parameter.
//
// state     | meaning
// DEVICE_ID | after rts: send REL_ID/ABS_ID at slot end
// IDLE      | sample joystick at cnt==CAPTURE_CNT, start packet if needed
// BYTE0..2  | send frame byte n at slot end
// BYTE3     | absolute mode only: send last frame byte
module cdi_pointer_gen
  import pointer_pkg::*;
#(
  parameter int         TICKS_PER_BYTE    = 250000,
  parameter int         TICKS_PER_BYTE_OC = 200000,
  parameter int         CNT_W             = 19,
  parameter logic [7:0] REL_ID            = 8'hCA,
  parameter logic [7:0] ABS_ID            = 8'hCB,
  parameter int         SPEED_SLOW        = 2,
  parameter int         SPEED_FAST        = 8,
  parameter int         SPEED_FAST_OC     = 7,
  parameter int         ACCEL_THRESH      = 5,
  parameter int         ACCEL_MAX         = 7,
  parameter int         X_MAX             = 767,
  parameter int         Y_MAX             = 559
`ifdef POINTER_ANALOG_EN
  ,
  parameter int         DEADZONE          = 16
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mister_joystick,
  input  logic        rts,
  input  logic        overclock,
  input  logic        abs_mode,
`ifdef POINTER_ANALOG_EN
  input  logic [15:0] joystick_analog,
`endif
  bytestream.source   serial_out
);

  e_state            state_q, state_d;
  e_mode             mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, tick;
  logic [7:0]        data_q, data_d;
  logic              write_q, write_d;
  frame_t            frame_q, frame_d;
  logic [1:0]        btn_hist_q, btn_hist_d;
  logic signed [7:0] x_hist_q, x_hist_d, y_hist_q, y_hist_d;

  logic              capture;
  logic [1:0]        btn;
  logic signed [7:0] dx, dy;
  logic [POS_W-1:0]  pos_x, pos_y, fx, fy;
  logic              pos_changed;
  logic              tx_rel, tx_abs;
  logic              unused_joy;

  assign unused_joy = ^mister_joystick[15:6];
  assign btn        = {mister_joystick[JOY_B1], mister_joystick[JOY_B2]};
  assign tick       = overclock ? CNT_W'(TICKS_PER_BYTE_OC) : CNT_W'(TICKS_PER_BYTE);
  assign capture    = !rts && (state_q == IDLE) && (cnt_q == CNT_W'(CAPTURE_CNT));

  pointer_motion #(
    .SPEED_SLOW    (SPEED_SLOW),
    .SPEED_FAST    (SPEED_FAST),
    .SPEED_FAST_OC (SPEED_FAST_OC),
    .ACCEL_THRESH  (ACCEL_THRESH),
    .ACCEL_MAX     (ACCEL_MAX),
    .X_MAX         (X_MAX),
    .Y_MAX         (Y_MAX)
`ifdef POINTER_ANALOG_EN
    ,
    .DEADZONE      (DEADZONE)
`endif
  ) u_motion (
    .clk           (clk),
    .reset_n       (reset_n),
    .dir_i         (mister_joystick[3:0]),
    .overclock_i   (overclock),
    .update_i      (capture),
    .abs_en_i      (mode_q == MODE_ABS),
`ifdef POINTER_ANALOG_EN
    .analog_i      (joystick_analog),
`endif
    .dx_o          (dx),
    .dy_o          (dy),
    .pos_x_o       (pos_x),
    .pos_y_o       (pos_y),
    .pos_changed_o (pos_changed)
  );

  // Relative mode keeps reporting while moving; absolute only on change.
  assign tx_rel = (btn != btn_hist_q) || (dx != x_hist_q) || (dy != y_hist_q) ||
                  (dx != '0) || (dy != '0);
  assign tx_abs = (btn != btn_hist_q) || pos_changed;

  assign fx = (mode_q == MODE_ABS) ? pos_x : {{2{dx[7]}}, dx};
  assign fy = (mode_q == MODE_ABS) ? pos_y : {{2{dy[7]}}, dy};

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q - 1'b1;
    data_d     = data_q;
    write_d    = 1'b0;
    frame_d    = frame_q;
    btn_hist_d = btn_hist_q;
    x_hist_d   = x_hist_q;
    y_hist_d   = y_hist_q;
    if (rts) begin
      state_d = DEVICE_ID;
      cnt_d   = tick;
      mode_d  = e_mode'(abs_mode);
    end else if (cnt_q == '0) begin
      cnt_d = tick;
      case (state_q)
        DEVICE_ID: begin
          data_d  = (mode_q == MODE_ABS) ? ABS_ID : REL_ID;
          write_d = 1'b1;
          state_d = IDLE;
        end
        IDLE: state_d = IDLE;
        BYTE0: begin
          data_d  = frame_q[0];
          write_d = 1'b1;
          state_d = BYTE1;
        end
        BYTE1: begin
          data_d  = frame_q[1];
          write_d = 1'b1;
          state_d = BYTE2;
        end
        BYTE2: begin
          data_d  = frame_q[2];
          write_d = 1'b1;
          state_d = (mode_q == MODE_ABS) ? BYTE3 : IDLE;
        end
        BYTE3: begin
          data_d  = frame_q[3];
          write_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = DEVICE_ID;
      endcase
    end else if (capture) begin
      frame_d    = build_frame(mode_q, btn[1], btn[0], fx, fy);
      btn_hist_d = btn;
      x_hist_d   = dx;
      y_hist_d   = dy;
      if ((mode_q == MODE_ABS) ? tx_abs : tx_rel)
        state_d = BYTE0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= DEVICE_ID;
      mode_q     <= MODE_REL;
      cnt_q      <= CNT_W'(TICKS_PER_BYTE);
      data_q     <= '0;
      write_q    <= 1'b0;
      frame_q    <= '0;
      btn_hist_q <= '0;
      x_hist_q   <= '0;
      y_hist_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      write_q    <= write_d;
      frame_q    <= frame_d;
      btn_hist_q <= btn_hist_d;
      x_hist_q   <= x_hist_d;
      y_hist_q   <= y_hist_d;
    end
  end

  assign serial_out.data  = data_q;
  assign serial_out.write = write_q;

endmodule

// File: tb/tb_cdi_pointer_gen.sv
// Directed bench for cdi_pointer_gen: expected bytes and spacing are queued as
// stimulus is applied and checked by a monitor as the DUT emits them.
module tb_cdi_pointer_gen;

  localparam int T     = 40;
  localparam int TOC   = 30;
  localparam int X_MAX = 767;
  localparam int Y_MAX = 559;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rts;
  logic        overclock;
  logic        abs_mode;
  logic [15:0] mister_joystick;
`ifdef POINTER_ANALOG_EN
  logic [15:0] joystick_analog = '0;
`endif

  bytestream serial_out();

  cdi_pointer_gen #(
    .TICKS_PER_BYTE    (T),
    .TICKS_PER_BYTE_OC (TOC)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mister_joystick (mister_joystick),
    .rts             (rts),
    .overclock       (overclock),
    .abs_mode        (abs_mode),
`ifdef POINTER_ANALOG_EN
    .joystick_analog (joystick_analog),
`endif
    .serial_out      (serial_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   last_wr = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_checks = 0;
  int   ax = X_MAX / 2;
  int   ay = Y_MAX / 2;
  int   mon_gap;
  exp_t mon_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && serial_out.write === 1'b1) begin
      mon_gap = cyc - last_wr;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        chk("spurious_write", {31'b0, serial_out.write}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("byte", {24'b0, serial_out.data}, {24'b0, mon_e.b});
        if (mon_e.gap != 0)
          chk("gap", mon_gap, mon_e.gap);
      end
    end
  end

  function automatic int slot();
    return (overclock ? TOC : T) + 1;
  endfunction

  function automatic int clampi(input int v, input int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  task automatic push(input logic [7:0] b, input int gap);
    exp_t e;
    e.b   = b;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_rel(input bit btn1, input bit btn2, input int x, input int y);
    logic [7:0] x8, y8;
    x8 = 8'(x);
    y8 = 8'(y);
    push(8'hC0 | {2'b00, btn1, btn2, 4'b0000} | {4'b0000, y8[7:6], x8[7:6]}, 0);
    push(8'h80 | {2'b00, x8[5:0]}, slot());
    push(8'h80 | {2'b00, y8[5:0]}, slot());
  endtask

  task automatic push_abs(input bit btn1, input bit btn2, input int x, input int y);
    logic [9:0] xv, yv;
    xv = 10'(x);
    yv = 10'(y);
    push(8'hC0 | {2'b00, btn1, btn2, xv[9:8], yv[9:8]}, 0);
    push(8'h80 | {2'b00, xv[5:0]}, slot());
    push(8'h80 | {2'b00, yv[5:0]}, slot());
    push(8'h80 | {4'b0000, xv[7:6], yv[7:6]}, slot());
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, exp_q.size(), 0);
    if (exp_q.size() != 0)
      exp_q.delete();
  endtask

  task automatic rts_restart(input bit mode);
    rts      = 1'b1;
    abs_mode = mode;
    idle(3);
    rts     = 1'b0;
    last_wr = cyc;
    push(mode ? 8'hCB : 8'hCA, slot());
  endtask

  task automatic rel_hold(input logic [15:0] joy, input int sx, input int sy, input int n);
    int fast, st;
    fast = overclock ? 7 : 8;
    mister_joystick = joy;
    for (int i = 0; i < n; i++) begin
      st = (i >= 5) ? fast : 2;
      push_rel(0, 0, sx * st, sy * st);
    end
    wait_drain("rel_hold", n * 4 * slot() + 200);
    mister_joystick = '0;
    push_rel(0, 0, 0, 0);
    wait_drain("rel_release", 4 * slot() + 100);
    idle(4 * slot());
  endtask

  task automatic abs_hold(input logic [15:0] joy, input int sx, input int sy);
    int acc, st, nx, ny, k;
    acc = 0;
    k   = 0;
    mister_joystick = joy;
    while (k < 200) begin
      st = (acc >= 5) ? (overclock ? 7 : 8) : 2;
      nx = clampi(ax + sx * st, X_MAX);
      ny = clampi(ay + sy * st, Y_MAX);
      if (nx == ax && ny == ay)
        break;
      ax = nx;
      ay = ny;
      push_abs(0, 0, ax, ay);
      if (acc < 7)
        acc++;
      k++;
    end
    wait_drain("abs_hold", (k + 1) * 5 * slot() + 200);
    idle(6 * slot());
    mister_joystick = '0;
    idle(4 * slot());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    rts             = 1'b1;
    overclock       = 1'b0;
    abs_mode        = 1'b0;
    mister_joystick = '0;
    idle(5);
    chk("rst_write", {31'b0, serial_out.write}, 32'd0);
    chk("rst_data", {24'b0, serial_out.data}, 32'd0);
    reset_n = 1'b1;
    idle(20);

    // Relative: device ID then silence while idle.
    rts_restart(0);
    wait_drain("id_rel", 2 * slot() + 10);
    idle(8 * slot());

    // Hold right: 5 slow reports then fast ones.
    rel_hold(16'h0001, 1, 0, 7);

    // B1 press and release.
    mister_joystick = 16'h0020;
    push_rel(1, 0, 0, 0);
    wait_drain("b1_press", 4 * slot() + 100);
    mister_joystick = '0;
    push_rel(0, 0, 0, 0);
    wait_drain("b1_release", 4 * slot() + 100);
    idle(8 * slot());

    // Left+right+up: left and up win.
    rel_hold(16'h000B, -1, -1, 6);

    // Overclocked: shorter slots and fast step of 7.
    overclock = 1'b1;
    idle(2 * slot());
    rel_hold(16'h0004, 0, 1, 7);
    overclock = 1'b0;
    idle(2 * slot());

    // Absolute mode from the centre, clamping at both edges.
    rts_restart(1);
    wait_drain("id_abs", 2 * slot() + 10);
    idle(6 * slot());
    abs_hold(16'h0002, -1, 0);
    abs_hold(16'h0004, 0, 1);

    // Abort after BYTE0: only ID follows.
    mister_joystick = 16'h0020;
    push_abs(1, 0, ax, ay);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    wait_drain("abort_b0", 3 * slot() + 100);
    rts_restart(1);
    wait_drain("abort_id", 2 * slot() + 10);
    idle(8 * slot());

    // Button release after restart, position retained.
    mister_joystick = '0;
    push_abs(0, 0, ax, ay);
    wait_drain("abs_release", 6 * slot() + 100);
    idle(8 * slot());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
